// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    LOAD,
    CALC,
    DONE
  } state_t;

  localparam int BOOTH_WIDTH = 4;

  // Wide enough to count WIDTH iterations for any WIDTH >= 1.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/booth_multiplier_step.sv
// One combinational radix-2 Booth iteration: conditional add/subtract of M,
// then arithmetic right shift of {A, Q, q_1}.
module booth_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             q_1_nxt
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  assign acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
  assign q_nxt   = {sum[0], q[WIDTH-1:1]};
  assign q_1_nxt = q[0];

endmodule

// File: rtl/booth_multiplier.sv
// Free-running iterative Booth multiplier: LOAD, WIDTH CALC steps, DONE.
// A new signed product appears every WIDTH+2 cycles with a one-cycle strobe.
module booth_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     mult_a,
  input  logic [WIDTH-1:0]     mult_b,
  output logic [2*WIDTH-1:0]   mult_y,
  output logic                 booth_done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH:0]   acc, m;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [CW-1:0]    cnt;
  logic             last_step;

  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             q_1_nxt;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .q       (q),
    .q_1     (q_1),
    .m       (m),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt),
    .q_1_nxt (q_1_nxt)
  );

  assign last_step = (state == CALC) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Result is registered on the final step so it is visible throughout DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      m          <= '0;
      q          <= '0;
      q_1        <= 1'b0;
      cnt        <= '0;
      mult_y     <= '0;
      booth_done <= 1'b0;
    end else begin
      booth_done <= 1'b0;
      case (state)
        LOAD: begin
          m   <= {mult_a[WIDTH-1], mult_a};
          q   <= mult_b;
          acc <= '0;
          q_1 <= 1'b0;
          cnt <= '0;
        end
        CALC: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          q_1 <= q_1_nxt;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            mult_y     <= {acc_nxt[WIDTH-1:0], q_nxt};
            booth_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed self-checking bench for booth_multiplier (WIDTH = 4).
module tb_booth_multiplier;

  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic [W-1:0]   mult_a;
  logic [W-1:0]   mult_b;
  logic [2*W-1:0] mult_y;
  logic           booth_done;

  int checks = 0;
  int errors = 0;

  booth_multiplier #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_y     (mult_y),
    .booth_done (booth_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until booth_done is seen; also records whether mult_y
  // held its previous value on every cycle before the pulse.
  task automatic wait_done(output int n, output logic stable);
    logic [2*W-1:0] held;
    logic           found;
    held   = mult_y;
    stable = 1'b1;
    found  = 1'b0;
    n      = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (booth_done === 1'b1) begin
        found = 1'b1;
        break;
      end
      if (mult_y !== held) stable = 1'b0;
    end
    checks++;
    assert (found === 1'b1) else begin
      errors++;
      $error("FAIL done_timeout: observed no pulse within %0d cycles expected pulse", n);
    end
  endtask

  task automatic product(input string tag, input int a, input int b, input logic [2*W-1:0] exp);
    int   n;
    logic st;
    mult_a = W'(a);
    mult_b = W'(b);
    wait_done(n, st);
    check({tag, "_spacing"}, 16'(n), 16'd6);
    check({tag, "_stable"}, {15'd0, st}, 16'd1);
    check(tag, {8'd0, mult_y}, {8'd0, exp});
  endtask

  initial begin
    int   n;
    int   bv;
    logic st;

    rst    = 1'b1;
    mult_a = '0;
    mult_b = '0;
    repeat (3) @(negedge clk);
    check("reset_y", {8'd0, mult_y}, 16'h0000);
    check("reset_done", {15'd0, booth_done}, 16'h0000);

    // First product: pulse lands in cycle WIDTH+1 counting this LOAD cycle as 0.
    mult_a = 4'd4;
    mult_b = 4'hB;
    rst    = 1'b0;
    wait_done(n, st);
    check("first_latency", 16'(n), 16'd5);
    check("first_y", {8'd0, mult_y}, 16'h00EC);
    @(negedge clk);
    check("done_width", {15'd0, booth_done}, 16'h0000);
    check("y_hold_after_done", {8'd0, mult_y}, 16'h00EC);
    wait_done(n, st);
    check("repeat_spacing", 16'(n), 16'd5);
    check("repeat_y", {8'd0, mult_y}, 16'h00EC);

    // Sweep b upward from -4, wrapping 7 -> -8; expected is 4*b truncated to 8 bits.
    for (int i = 1; i < 20; i++) begin
      bv = -5 + i;
      if (bv > 7) bv -= 16;
      product("sweep", 4, bv, 8'(4 * bv));
    end

    product("b_zero", 4, 0, 8'h00);
    product("b_max", 4, 7, 8'h1C);
    product("b_min", 4, -8, 8'hE0);
    product("neg8_neg8", -8, -8, 8'h40);
    product("p7_neg8", 7, -8, 8'hC8);
    product("neg8_p7", -8, 7, 8'hC8);
    product("neg1_neg1", -1, -1, 8'h01);

    // Operand change mid-computation only affects the following product.
    mult_a = 4'd4;
    mult_b = 4'd3;
    @(negedge clk);
    @(negedge clk);
    mult_b = 4'hE;
    wait_done(n, st);
    check("midcalc_spacing", 16'(n), 16'd4);
    check("midcalc_old_b", {8'd0, mult_y}, 16'h000C);
    wait_done(n, st);
    check("midcalc_new_b_spacing", 16'(n), 16'd6);
    check("midcalc_new_b", {8'd0, mult_y}, 16'h00F8);

    // Reset during CALC discards the partial product.
    mult_a = 4'd5;
    mult_b = 4'd3;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_y", {8'd0, mult_y}, 16'h0000);
    check("midreset_done", {15'd0, booth_done}, 16'h0000);
    rst = 1'b0;
    wait_done(n, st);
    check("post_reset_latency", 16'(n), 16'd5);
    check("post_reset_stable", {15'd0, st}, 16'd1);
    check("post_reset_y", {8'd0, mult_y}, 16'h000F);

    product("neg3_p5", -3, 5, 8'hF1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
